// File: rtl/zprize_red_pkg.sv
// Shared types and constants for the bit-serial modular reducer.
package zprize_red_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } red_state_e;

    localparam int DEFAULT_W = 384;
    localparam int DEFAULT_M = 32;
    localparam int CNT_W     = $clog2(2 * DEFAULT_W);

    // BLS12-381 base field modulus.
    localparam logic [DEFAULT_W-1:0] DEFAULT_P =
        384'h1A0111EA397FE69A4B1BA7B6434BACD764774B84F38512BF6730D2A0F6B0F6241EABFFFEB153FFFFB9FEFFFFFFFFAAAB;

    function automatic int cnt_width(input int w);
        return $clog2(2 * w);
    endfunction

endpackage

// File: rtl/zprize_red_step.sv
// One restoring-reduction step: shift one input bit into r, subtract P once if needed.
module zprize_red_step
    import zprize_red_pkg::*;
#(
    parameter int            W = DEFAULT_W,
    parameter logic [W-1:0]  P = W'(DEFAULT_P)
) (
    input  logic [W-1:0] r_i,
    input  logic         bit_i,
    output logic [W-1:0] r_o
);

    localparam logic [W:0] PExt = {1'b0, P};

    logic [W:0]   t;
    logic [W-1:0] diffLow;

    // r_i < P guarantees t - P < 2^W, so the low W bits of the difference are exact.
    always_comb begin
        t       = {r_i, bit_i};
        diffLow = t[W-1:0] - P;
        r_o     = (t >= PExt) ? diffLow : t[W-1:0];
    end

endmodule

// File: rtl/zprize_red_seq.sv
// Sequential modular reducer: consumes a 2W-bit product MSB first, one bit per cycle,
// and returns the product mod P with its metadata through a valid/ready handshake.
module zprize_red_seq
    import zprize_red_pkg::*;
#(
    parameter int            W = DEFAULT_W,
    parameter logic [W-1:0]  P = W'(DEFAULT_P),
    parameter int            M = DEFAULT_M
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2*W-1:0]   in0,
    input  logic [M-1:0]     m_i,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out0,
    output logic [M-1:0]     m_o
);

    localparam int             CntW    = cnt_width(W);
    localparam logic [CntW-1:0] CntLoad = CntW'(2 * W - 2);

    red_state_e      state_q, state_d;
    logic [2*W-1:0]  x_q, x_d;
    logic [W-1:0]    r_q, r_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [M-1:0]    mHold_q, mHold_d;
    logic [W-1:0]    res_q, res_d;
    logic [M-1:0]    mOut_q, mOut_d;
    logic            valid_q, valid_d;

    logic [W-1:0]    rStep;
    logic            loadOp;

    zprize_red_step #(
        .W (W),
        .P (P)
    ) u_step (
        .r_i   (r_q),
        .bit_i (x_q[2*W-1]),
        .r_o   (rStep)
    );

    assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign loadOp    = in_valid && in_ready;
    assign out_valid = valid_q;
    assign out0      = res_q;
    assign m_o       = mOut_q;

    // The first step runs in the accept cycle (r starts at 0, so it is just the MSB),
    // which keeps latency at 2W cycles and lets DONE overlap the next accept.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        mHold_d = mHold_q;
        res_d   = res_q;
        mOut_d  = mOut_q;
        valid_d = valid_q;

        case (state_q)
            IDLE: ;
            RUN: begin
                r_d = rStep;
                x_d = x_q << 1;
                if (cnt_q == '0) begin
                    state_d = DONE;
                    valid_d = 1'b1;
                    res_d   = rStep;
                    mOut_d  = mHold_q;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (loadOp) begin
            state_d = RUN;
            x_d     = {in0[2*W-2:0], 1'b0};
            r_d     = {{(W-1){1'b0}}, in0[2*W-1]};
            cnt_d   = CntLoad;
            mHold_d = m_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            x_q     <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            mHold_q <= '0;
            res_q   <= '0;
            mOut_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            mHold_q <= mHold_d;
            res_q   <= res_d;
            mOut_q  <= mOut_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: tb/tb_zprize_red_seq.sv
// Bench for zprize_red_seq: W=8/P=251 instance with table, corner and random tests,
// plus a W=384 instance with the default modulus checked against wide modulo.
module tb_zprize_red_seq;
    import zprize_red_pkg::*;

    typedef struct {
        logic [7:0] res;
        logic [7:0] meta;
    } exp_t;

    typedef struct {
        logic [15:0] value;
        logic [7:0]  meta;
        logic [7:0]  expected;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, inValid, inReady, outValid, outReady;
    logic [15:0] in0;
    logic [7:0]  mI, out0, mO;

    logic         rstBig, bigInValid, bigInReady, bigOutValid, bigOutReady;
    logic [767:0] bigIn0;
    logic [31:0]  bigMI, bigMO;
    logic [383:0] bigOut0;

    zprize_red_seq #(.W(8), .P(8'd251), .M(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (inValid),
        .in_ready  (inReady),
        .in0       (in0),
        .m_i       (mI),
        .out_valid (outValid),
        .out_ready (outReady),
        .out0      (out0),
        .m_o       (mO)
    );

    zprize_red_seq #(.W(384), .M(32)) dutBig (
        .clk       (clk),
        .rst       (rstBig),
        .in_valid  (bigInValid),
        .in_ready  (bigInReady),
        .in0       (bigIn0),
        .m_i       (bigMI),
        .out_valid (bigOutValid),
        .out_ready (bigOutReady),
        .out0      (bigOut0),
        .m_o       (bigMO)
    );

    int   testsRun    = 0;
    int   testsFailed = 0;
    int   cycle       = 0;
    int   acceptCycle = 0;
    int   riseCycle[$];
    exp_t sbQ[$];
    logic prevValid   = 1'b0;
    bit   randomReady = 1'b0;
    bit   bigDone     = 1'b0;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [767:0] actual, input logic [767:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Scoreboard monitor: a result is consumed on out_valid && out_ready.
    always @(negedge clk) begin
        exp_t e;
        if (outValid && !prevValid) riseCycle.push_back(cycle);
        prevValid = outValid;
        if (outValid && outReady) begin
            if (sbQ.size() == 0) begin
                testsRun++;
                testsFailed++;
                $display("[TB] FAIL unexpected result: got %0d with empty scoreboard", out0);
            end else begin
                e = sbQ.pop_front();
                checkOutput("result", 768'(out0), 768'(e.res));
                checkOutput("meta", 768'(mO), 768'(e.meta));
            end
        end
    end

    always @(posedge clk) begin
        if (randomReady) begin
            #1 outReady = ($urandom_range(0, 3) != 0);
        end
    end

    // Called just after a rising edge; returns just after a rising edge.
    task automatic applyStimulus(input logic [15:0] v, input logic [7:0] m, input logic [7:0] expRes,
                                 input int maxWait, output bit accepted);
        in0      = v;
        mI       = m;
        inValid  = 1'b1;
        accepted = 1'b0;
        for (int i = 0; i < maxWait; i++) begin
            @(negedge clk);
            if (inReady) begin
                accepted    = 1'b1;
                acceptCycle = cycle;
                sbQ.push_back('{expRes, m});
                break;
            end
        end
        @(posedge clk);
        #1 inValid = 1'b0;
    endtask

    task automatic waitDrain(input int maxCycles);
        bit drained = 1'b0;
        for (int i = 0; i < maxCycles; i++) begin
            @(negedge clk);
            #1;
            if (sbQ.size() == 0 && !outValid) begin
                drained = 1'b1;
                break;
            end
        end
        checkOutput("drain", 768'(drained), 768'(1));
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t vecs[9];
        bit   acc;
        int   lat;
        bit   holdOk, readyLow;
        logic [15:0] v;

        vecs[0] = '{16'd0,     8'hA5, 8'd0};
        vecs[1] = '{16'hFFFF,  8'h11, 8'd24};
        vecs[2] = '{16'd251,   8'h22, 8'd0};
        vecs[3] = '{16'd250,   8'h33, 8'd250};
        vecs[4] = '{16'd63000, 8'h44, 8'd250};
        vecs[5] = '{16'd502,   8'h55, 8'd0};
        vecs[6] = '{16'd62750, 8'h66, 8'd0};
        vecs[7] = '{16'd1000,  8'h77, 8'd247};
        vecs[8] = '{16'd300,   8'h88, 8'd49};

        rst = 1'b0; inValid = 1'b0; outReady = 1'b1; in0 = '0; mI = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        checkOutput("reset in_ready", 768'(inReady), 768'(1));
        checkOutput("reset out_valid", 768'(outValid), 768'(0));
        checkOutput("reset out0", 768'(out0), 768'(0));
        checkOutput("reset m_o", 768'(mO), 768'(0));
        @(posedge clk);
        #1;

        for (int k = 0; k < 9; k++) begin
            riseCycle.delete();
            applyStimulus(vecs[k].value, vecs[k].meta, vecs[k].expected, 40, acc);
            checkOutput("vector accept", 768'(acc), 768'(1));
            waitDrain(40);
            lat = (riseCycle.size() > 0) ? riseCycle[0] - acceptCycle : -1;
            checkOutput("vector latency", 768'(lat), 768'(16));
        end

        // Backpressure: result must hold and a second operand must be refused.
        outReady = 1'b0;
        applyStimulus(16'd1234, 8'h5C, 8'd230, 40, acc);
        checkOutput("bp accept", 768'(acc), 768'(1));
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (outValid) break;
        end
        checkOutput("bp out_valid", 768'(outValid), 768'(1));
        @(posedge clk);
        #1;
        inValid = 1'b1; in0 = 16'd777; mI = 8'hEE;
        holdOk = 1'b1; readyLow = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!(outValid && out0 == 8'd230 && mO == 8'h5C)) holdOk = 1'b0;
            if (inReady) readyLow = 1'b0;
        end
        checkOutput("bp hold", 768'(holdOk), 768'(1));
        checkOutput("bp in_ready low", 768'(readyLow), 768'(1));
        @(posedge clk);
        #1;
        inValid  = 1'b0;
        outReady = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("bp release out_valid", 768'(outValid), 768'(0));
        checkOutput("bp release in_ready", 768'(inReady), 768'(1));
        repeat (20) @(posedge clk);
        #1;
        waitDrain(40);

        // Back-to-back with in_valid held: zero-bubble results 16 cycles apart.
        riseCycle.delete();
        applyStimulus(16'd1000, 8'h01, 8'd247, 40, acc);
        applyStimulus(16'd5000, 8'h02, 8'd231, 40, acc);
        checkOutput("b2b second accept", 768'(acc), 768'(1));
        waitDrain(60);
        checkOutput("b2b pulses", 768'(riseCycle.size()), 768'(2));
        lat = (riseCycle.size() > 1) ? riseCycle[1] - riseCycle[0] : -1;
        checkOutput("b2b spacing", 768'(lat), 768'(16));

        // Asynchronous reset mid-RUN discards the operation.
        applyStimulus(16'd4321, 8'h3C, 8'd54, 40, acc);
        repeat (6) @(posedge clk);
        #3 rst = 1'b0;
        sbQ.delete();
        #1;
        checkOutput("mid reset out_valid", 768'(outValid), 768'(0));
        checkOutput("mid reset out0", 768'(out0), 768'(0));
        checkOutput("mid reset m_o", 768'(mO), 768'(0));
        checkOutput("mid reset in_ready", 768'(inReady), 768'(1));
        @(posedge clk);
        #1 rst = 1'b1;
        riseCycle.delete();
        repeat (30) @(posedge clk);
        #1;
        checkOutput("no output after reset", 768'(riseCycle.size()), 768'(0));
        applyStimulus(16'd300, 8'h99, 8'd49, 40, acc);
        waitDrain(40);

        // Random regression with random gaps and random out_ready.
        randomReady = 1'b1;
        for (int k = 0; k < 1500; k++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            v = 16'($urandom);
            applyStimulus(v, 8'($urandom), 8'(v % 16'd251), 200, acc);
            checkOutput("random accept", 768'(acc), 768'(1));
        end
        randomReady = 1'b0;
        @(posedge clk);
        #2 outReady = 1'b1;
        waitDrain(200);

        for (int i = 0; i < 20000; i++) begin
            if (bigDone) break;
            @(posedge clk);
        end
        checkOutput("big test finished", 768'(bigDone), 768'(1));

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    // W=384 path with the default modulus.
    initial begin
        logic [767:0] pw;
        logic [767:0] ops[$];
        logic [767:0] r;
        logic [31:0]  meta;
        bit           seen;

        pw = {384'b0, DEFAULT_P};
        ops.push_back('0);
        ops.push_back(pw);
        ops.push_back(pw * 768'(3));
        ops.push_back(pw * pw);
        ops.push_back(pw * pw - 768'(1));
        ops.push_back('1);
        for (int k = 0; k < 6; k++) begin
            for (int j = 0; j < 24; j++) r[j*32 +: 32] = $urandom;
            ops.push_back(r);
        end

        rstBig = 1'b0; bigInValid = 1'b0; bigOutReady = 1'b0; bigIn0 = '0; bigMI = '0;
        repeat (3) @(posedge clk);
        #1 rstBig = 1'b1;
        #1;
        checkOutput("big reset in_ready", 768'(bigInReady), 768'(1));
        checkOutput("big reset out_valid", 768'(bigOutValid), 768'(0));

        foreach (ops[k]) begin
            @(posedge clk);
            #1;
            meta       = $urandom;
            bigIn0     = ops[k];
            bigMI      = meta;
            bigInValid = 1'b1;
            seen       = 1'b0;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                if (bigInReady) begin
                    seen = 1'b1;
                    break;
                end
            end
            checkOutput("big accept", 768'(seen), 768'(1));
            @(posedge clk);
            #1 bigInValid = 1'b0;
            for (int i = 0; i < 800; i++) begin
                @(negedge clk);
                if (bigOutValid) break;
            end
            checkOutput("big out_valid", 768'(bigOutValid), 768'(1));
            checkOutput("big result", 768'(bigOut0), ops[k] % pw);
            checkOutput("big meta", 768'(bigMO), 768'(meta));
            @(posedge clk);
            #1 bigOutReady = 1'b1;
            @(posedge clk);
            #1 bigOutReady = 1'b0;
        end
        bigDone = 1'b1;
    end

endmodule
